serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 114 +++++++++++
 tb/tb_serial_add_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller, LSB first, one result bit per clock.
// A single full adder (two half adders plus an OR) is time-shared across all bit
// positions, and a carry flop links one bit position to the next.
// The FSM steps through IDLE -> ADD (WIDTH edges) -> DONE (one cycle) -> IDLE.
// Optional feature: define SERIAL_ADD_SUB_EN to add the `sub` port. With sub=1
// the block computes a - b, giving sum = a + ~b + 1; cout is then borrow-not.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Full adder built from two half adders plus an OR.
  logic b_bit, s1, c1, s, c2, fa_c;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_r;
  assign b_bit = b_sr[0] ^ sub_r;
`else
  assign b_bit = b_sr[0];
`endif

  assign s1   = a_sr[0] ^ b_bit;
  assign c1   = a_sr[0] & b_bit;
  assign s    = s1 ^ carry;
  assign c2   = s1 & carry;
  assign fa_c = c1 | c2;

  // Control FSM plus datapath. sum and cout change only at completion, so no
  // partial result is ever visible on them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
            // The +1 of two's-complement subtraction enters as the initial carry.
            sub_r <= sub;
            carry <= sub;
`else
            carry <= 1'b0;
`endif
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          res   <= {s, res[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_c;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= {s, res[WIDTH-1:1]};
            cout  <= fa_c;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // A start seen here is dropped; it is never queued.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: a directed vector table, hand-written multi-cycle
// sequences (start ignored while busy, reset abort, WIDTH=4 instance) and random
// operands checked against an arithmetic reference model.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, sub_v;
  logic [7:0] a, b, sum;
  logic       busy, done, cout;
  logic       start4;
  logic [3:0] a4, b4, sum4;
  logic       busy4, done4, cout4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub_v),
`endif
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
`ifdef SERIAL_ADD_SUB_EN
    .sub(1'b0),
`endif
    .a(a4), .b(b4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vsub;
    logic       scramble;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Counts negedges until done is seen, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Reference model: plain integer arithmetic on WIDTH+1 bits.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + 9'd1;
    return {1'b0, x} + {1'b0, y};
  endfunction

  // One full operation, starting and ending on a negedge.
  task automatic run_op(input string nm, input logic [7:0] x, input logic [7:0] y,
                        input logic s, input logic scr,
                        input logic [7:0] es, input logic ec);
    logic [7:0] prev;
    int cyc;
    prev = sum;
    start = 1'b1; a = x; b = y; sub_v = s;
    @(posedge clk);                       // E0
    @(negedge clk);
    start = 1'b0;
    if (scr) begin a = 8'h00; b = 8'h00; end
    chk({nm, " busy_after_E0"}, busy, 1);
    @(negedge clk); @(negedge clk);
    chk({nm, " sum_held"}, sum, prev);
    cyc = 2;
    begin
      int extra;
      wait_done(extra);
      cyc += extra;
    end
    chk({nm, " latency"}, cyc, 8);
    chk({nm, " sum"}, sum, es);
    chk({nm, " cout"}, cout, ec);
    chk({nm, " busy_in_done"}, busy, 1);
    @(negedge clk);
    chk({nm, " done_pulse_1cyc"}, done, 0);
    chk({nm, " busy_idle"}, busy, 0);
  endtask

  vec_t vecs[$];

  initial begin
    int cyc;
    int dcount;
    logic [8:0] m;
    logic [7:0] rx, ry;
    logic       rs;

    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h5A, 8'hA5, 1'b0, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFE, 1'b1});
    vecs.push_back('{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0});
    vecs.push_back('{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1});
`endif

    rst = 1'b1; start = 1'b1; sub_v = 1'b0; a = 8'hFF; b = 8'hFF;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    repeat (3) @(negedge clk);
    // Reset state, with start held high alongside rst.
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sum", sum, 0);
    chk("rst cout", cout, 0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst start_ignored", busy, 0);

    // Directed table.
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vsub,
             vecs[i].scramble, vecs[i].exp_sum, vecs[i].exp_cout);

    // Start during ADD (sampled at E3) and during DONE are ignored.
    start = 1'b1; a = 8'h10; b = 8'h20;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk); start = 1'b0;         // after E3
    wait_done(cyc);
    chk("ign latency", cyc, 5);
    chk("ign sum", sum, 8'h30);
    start = 1'b1; a = 8'h03; b = 8'h04;   // sampled at E9 while in DONE
    @(negedge clk);
    chk("ign done_start busy", busy, 0);
    @(negedge clk); start = 1'b0;         // sampled at E10 in IDLE: accepted
    chk("ign accept busy", busy, 1);
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1) dcount++;
      @(negedge clk);
    end
    chk("ign single_pulse", dcount, 1);
    chk("ign accept sum", sum, 8'h07);

    // Reset at E4 aborts the operation with no done pulse.
    start = 1'b1; a = 8'hC3; b = 8'h3C;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort sum", sum, 0);
    chk("abort cout", cout, 0);
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1) dcount++;
      @(negedge clk);
    end
    chk("abort no_done", dcount, 0);
    run_op("after_abort", 8'hC3, 8'h3C, 1'b0, 1'b0, 8'hFF, 1'b0);

    // WIDTH=4 instance.
    start4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    @(posedge clk);
    @(negedge clk); start4 = 1'b0;
    cyc = 0;
    while (done4 !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("w4 latency", cyc, 4);
    chk("w4 sum", sum4, 4'hE);
    chk("w4 cout", cout4, 1);

    // Random operands against the model.
    for (int r = 0; r < 30; r++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      m = model(rx, ry, rs);
      run_op($sformatf("rnd%0d", r), rx, ry, rs, 1'($urandom), m[7:0], m[8]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
